shift_reg_piso_tx: RTL
======================

# shift_reg_piso_tx

Parallel-in serial-out transmitter. It accepts one `WIDTH`-bit word through a valid/ready load handshake, then shifts it out one bit per clock with a qualifying valid strobe. It is the transmit end for the team's parallel shift-register blocks, and it drives the serial link that a matching deserializer samples on the same clock.

## Interface
- `WIDTH`, default 4: data word width in bits; must be ≥ 2.
- `MSB_FIRST`, default 1: 1 sends bit `WIDTH-1` first; 0 sends bit 0 first.

- `clk`  in  1: single clock; all logic updates on the rising edge.
- `reset_n`  in  1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `d`  in  WIDTH: parallel word to transmit.
- `load_valid`  in  1: `d` is valid.
- `load_ready`  out  1: transmitter can accept a word this cycle. Combinational from state and counter.
- `sout`  out  1: serial data bit, registered.
- `sout_valid`  out  1: `sout` carries a frame bit this cycle, registered.
- `busy`  out  1: high while a frame is being shifted.
- `done`  out  1: one-cycle pulse, high while the last frame bit is on `sout`.

## Operation
- FSM states: `IDLE` and `SHIFT`.
- Frame length: `FRAME_LEN = WIDTH`, or `WIDTH+1` with parity (see Configuration).
- Accept: a word is accepted on a rising edge where `load_valid && load_ready`. On that edge:
  - the shift register captures `d`;
  - `sout` takes the first bit and `sout_valid` goes to 1;
  - the bit counter loads `FRAME_LEN-1`;
  - the state goes to `SHIFT`.
- `SHIFT`: on each edge the register shifts toward the output end, `sout` takes the next bit, and the counter decrements.
- `load_ready` is 1 in `IDLE`. In `SHIFT` it is 1 only when the counter equals 0 (last bit on the wire).
- At the last bit (counter = 0), on the next edge:
  - with `load_valid` high, the new word is accepted. This is back-to-back: no gap and no idle cycle.
  - otherwise the state returns to `IDLE`, `sout_valid` goes to 0 and `sout` to 0.
- `d` and `load_valid` are ignored while `load_ready` = 0. The captured word is immune to changes on `d`.
- `busy` = (state == `SHIFT`). `done` = `busy && counter == 0`.
- Reset values (when `reset_n` = 0 at an edge): state `IDLE`, `sout` 0, `sout_valid` 0, counter 0, shift register 0. After reset `load_ready` is 1, `busy` 0, `done` 0.
- Reset during a frame: the frame is abandoned. Remaining bits are never sent and no `done` is produced. Reset takes priority over a simultaneous accept.

## Timing
- Latency: the first bit is on `sout` in the cycle right after the accept edge.
- Each bit is held exactly one clock. Frame duration is `FRAME_LEN` cycles of `sout_valid` = 1.
- Sustained throughput: one word per `FRAME_LEN` cycles with `load_valid` held high.
- The receiver samples `sout` on any rising edge where `sout_valid` = 1.

## Configuration
- Macro: `PISO_PARITY_EN`.
- Defined:
  - one even-parity bit (XOR of the captured word) is appended after the data bits;
  - `FRAME_LEN = WIDTH+1`;
  - `done` is asserted on the parity bit.
- Undefined: no parity logic, `FRAME_LEN = WIDTH`, and `done` is asserted on the final data bit.

## Structure
- Shared package `shift_reg_pkg` holds:
  - the FSM state enum typedef (`IDLE`, `SHIFT`);
  - a function computing the counter width, `$clog2(WIDTH+1)`.
- One sub-module, `piso_bit_counter`, provides a loadable down-counter with a zero flag. The top-level FSM and shift register instantiate it.

## Test plan
- `WIDTH`=4, `MSB_FIRST`=1, `d`=4'b1011, one-cycle `load_valid` → `sout` 1,0,1,1 over four consecutive cycles with `sout_valid`=1; `done` high only in cycle 4; `sout_valid`=0 in cycle 5.
- `MSB_FIRST`=0, `d`=4'b1011 → `sout` 1,1,0,1; `busy` high for exactly 4 cycles.
- `load_valid` held high with `d`=4'hA, then 4'h5 presented during the last bit → 8 contiguous valid bits 1,0,1,0,0,1,0,1; `load_ready` high only in the two last-bit cycles and `IDLE`.
- `d`=4'hF accepted; `d` changed to 4'h0 and `load_valid` pulsed at bit 2 → output still 1,1,1,1; the second request is not accepted.
- `reset_n`=0 for one edge after 2 bits of 4'hC → next cycle `sout_valid`=0, `sout`=0, `busy`=0, `load_ready`=1; no `done`; a new word 4'h3 then transmits correctly.
- With `PISO_PARITY_EN`, `d`=4'b1011 → `sout` 1,0,1,1,1 (5 valid cycles), `done` on the 5th; `d`=4'b1001 → parity bit 0.

Source files
------------

// File: rtl/shift_reg_pkg.sv
// Shared types and helpers for the parallel shift-register blocks.
package shift_reg_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Wide enough to hold WIDTH, which covers the parity-extended frame count.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Loadable down-counter with a zero flag; tracks the bits left in a frame.
module piso_bit_counter #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          zero
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/shift_reg_piso_tx.sv
// Parallel-in serial-out transmitter with valid/ready load and back-to-back frames.
// Optional even-parity bit appended to each frame when PISO_PARITY_EN is defined.
module shift_reg_piso_tx
  import shift_reg_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

`ifdef PISO_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int CW = cnt_width(WIDTH);

  state_e               state_q, state_d;
  logic [FRAME_LEN-1:0] sh_q, sh_d;
  logic                 sout_q, sout_d;
  logic                 sout_valid_q, sout_valid_d;
  logic [FRAME_LEN-1:0] frame;
  logic                 cnt_zero;
  logic                 accept;

  // The output end of the frame is the MSB or LSB depending on bit order.
  function automatic logic first_bit(input logic [FRAME_LEN-1:0] f);
    return MSB_FIRST ? f[FRAME_LEN-1] : f[0];
  endfunction

  function automatic logic [FRAME_LEN-1:0] shift_one(input logic [FRAME_LEN-1:0] f);
    return MSB_FIRST ? {f[FRAME_LEN-2:0], 1'b0} : {1'b0, f[FRAME_LEN-1:1]};
  endfunction

  always_comb begin
`ifdef PISO_PARITY_EN
    // Parity sits at the far end so it leaves the wire after all data bits.
    frame = MSB_FIRST ? {d, ^d} : {^d, d};
`else
    frame = d;
`endif
  end

  assign load_ready = (state_q == IDLE) || cnt_zero;
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_d      = state_q;
    sh_d         = sh_q;
    sout_d       = sout_q;
    sout_valid_d = sout_valid_q;
    if (accept) begin
      state_d      = SHIFT;
      sh_d         = shift_one(frame);
      sout_d       = first_bit(frame);
      sout_valid_d = 1'b1;
    end else if (state_q == SHIFT) begin
      if (cnt_zero) begin
        state_d      = IDLE;
        sout_d       = 1'b0;
        sout_valid_d = 1'b0;
      end else begin
        sh_d   = shift_one(sh_q);
        sout_d = first_bit(sh_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      sh_q         <= '0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sh_q         <= sh_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
    end
  end

  piso_bit_counter #(
    .CW(CW)
  ) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (accept),
    .load_val(CW'(FRAME_LEN - 1)),
    .dec     (state_q == SHIFT),
    .zero    (cnt_zero)
  );

  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign busy       = (state_q == SHIFT);
  assign done       = busy && cnt_zero;

endmodule
